// File: rtl/mc_register_file.sv
// Multicycle register file with A/B operand latches and write counter.
// Define MC_RF_BYPASS_EN to forward same-edge write data into A/B.
module mc_register_file #(
  parameter int DW = 32,
  parameter int AW = 5
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [AW-1:0] rs,
  input  logic [AW-1:0] rt,
  input  logic [AW-1:0] RFWA,
  input  logic [DW-1:0] RFWD,
  input  logic          RFWE,
  input  logic          ABWE,
  input  logic [AW-1:0] dbg_addr,
  output logic [DW-1:0] A,
  output logic [DW-1:0] B,
  output logic [DW-1:0] dbg_data,
  output logic [15:0]   wr_count
);

  localparam int NREG = 1 << AW;

  logic [DW-1:0] regs_q [1:NREG-1];
  logic [DW-1:0] regs_d [1:NREG-1];
  logic [DW-1:0] a_q, a_d;
  logic [DW-1:0] b_q, b_d;
  logic [15:0]   cnt_q, cnt_d;

  logic          wr_en;
  logic [DW-1:0] rd_a;
  logic [DW-1:0] rd_b;

  assign wr_en = RFWE && (RFWA != '0);

  assign rd_a = (rs == '0) ? '0 : regs_q[rs];
  assign rd_b = (rt == '0) ? '0 : regs_q[rt];
  assign dbg_data =
    (dbg_addr == '0) ? '0 : regs_q[dbg_addr];

  always_comb begin
    regs_d = regs_q;
    if (wr_en) regs_d[RFWA] = RFWD;
  end

  always_comb begin
    a_d = a_q;
    b_d = b_q;
    if (ABWE) begin
      a_d = rd_a;
      b_d = rd_b;
`ifdef MC_RF_BYPASS_EN
      // register 0 never matches: wr_en excludes it
      if (wr_en && RFWA == rs) a_d = RFWD;
      if (wr_en && RFWA == rt) b_d = RFWD;
`endif
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    if (wr_en && cnt_q != 16'hFFFF)
      cnt_d = cnt_q + 16'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 1; i < NREG; i++)
        regs_q[i] <= '0;
      a_q   <= '0;
      b_q   <= '0;
      cnt_q <= '0;
    end else begin
      regs_q <= regs_d;
      a_q    <= a_d;
      b_q    <= b_d;
      cnt_q  <= cnt_d;
    end
  end

  assign A        = a_q;
  assign B        = b_q;
  assign wr_count = cnt_q;

endmodule

// File: tb/tb_mc_register_file.sv
// Self-checking bench for mc_register_file: vector table,
// hand sequences, and random traffic against a reference model.
module tb_mc_register_file;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [4:0]  rs, rt, RFWA, dbg_addr;
  logic [31:0] RFWD;
  logic        RFWE, ABWE;
  logic [31:0] A, B, dbg_data;
  logic [15:0] wr_count;

  int checks = 0;
  int failures = 0;

  mc_register_file #(.DW(32), .AW(5)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .rs       (rs),
    .rt       (rt),
    .RFWA     (RFWA),
    .RFWD     (RFWD),
    .RFWE     (RFWE),
    .ABWE     (ABWE),
    .dbg_addr (dbg_addr),
    .A        (A),
    .B        (B),
    .dbg_data (dbg_data),
    .wr_count (wr_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic [4:0]  wa;
    logic [31:0] wd;
    logic        abwe;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  dbg;
    logic [31:0] ea;
    logic [31:0] eb;
    logic [31:0] ed;
    logic [15:0] ec;
  } vec_t;

  vec_t vecs [$];

  // reference model state
  logic [31:0] m_mem [32];
  logic [31:0] m_a, m_b;
  int          m_cnt;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic vec_t mk(
    input logic we, input logic [4:0] wa,
    input logic [31:0] wd, input logic abwe,
    input logic [4:0] r_s, input logic [4:0] r_t,
    input logic [4:0] dbg, input logic [31:0] ea,
    input logic [31:0] eb, input logic [31:0] ed,
    input logic [15:0] ec);
    vec_t v;
    v.we = we; v.wa = wa; v.wd = wd; v.abwe = abwe;
    v.rs = r_s; v.rt = r_t; v.dbg = dbg;
    v.ea = ea; v.eb = eb; v.ed = ed; v.ec = ec;
    return v;
  endfunction

  task automatic drive(input logic we, input logic [4:0] wa,
                       input logic [31:0] wd, input logic ab,
                       input logic [4:0] r_s, input logic [4:0] r_t,
                       input logic [4:0] dbg);
    RFWE = we; RFWA = wa; RFWD = wd; ABWE = ab;
    rs = r_s; rt = r_t; dbg_addr = dbg;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    step();
    step();
    rst_n = 1'b1;
  endtask

  function automatic logic [31:0] m_rd(input logic [4:0] x);
    return (x == 5'd0) ? 32'd0 : m_mem[x];
  endfunction

  task automatic m_clear();
    for (int i = 0; i < 32; i++) m_mem[i] = 32'd0;
    m_a = 32'd0;
    m_b = 32'd0;
    m_cnt = 0;
  endtask

  logic [31:0] coll_a;
  logic        byp;

  initial begin
    #1000000;
    $display("FAIL watchdog: sim time exceeded");
    $fatal(1, "watchdog");
  end

  initial begin
`ifdef MC_RF_BYPASS_EN
    byp = 1'b1;
`else
    byp = 1'b0;
`endif
    coll_a = byp ? 32'h2 : 32'h1;

    // we wa wd abwe rs rt dbg | A B dbg cnt
    vecs.push_back(mk(1, 8, 32'h12345678, 0, 0, 0, 8,
      0, 0, 32'h12345678, 1));
    vecs.push_back(mk(1, 9, 32'hCAFEF00D, 0, 0, 0, 9,
      0, 0, 32'hCAFEF00D, 2));
    vecs.push_back(mk(0, 0, 0, 1, 8, 9, 8,
      32'h12345678, 32'hCAFEF00D, 32'h12345678, 2));
    vecs.push_back(mk(1, 0, 32'hFFFFFFFF, 0, 8, 9, 0,
      32'h12345678, 32'hCAFEF00D, 0, 2));
    vecs.push_back(mk(0, 0, 0, 1, 0, 0, 0,
      0, 0, 0, 2));
    vecs.push_back(mk(0, 0, 0, 1, 8, 8, 9,
      32'h12345678, 32'h12345678, 32'hCAFEF00D, 2));
    for (int i = 0; i < 3; i++)
      vecs.push_back(mk(0, 0, 0, 0, 9, 9, 8,
        32'h12345678, 32'h12345678, 32'h12345678, 2));
    vecs.push_back(mk(1, 3, 32'h1, 0, 9, 9, 3,
      32'h12345678, 32'h12345678, 32'h1, 3));
    vecs.push_back(mk(1, 3, 32'h2, 1, 3, 8, 3,
      coll_a, 32'h12345678, 32'h2, 4));
    vecs.push_back(mk(0, 0, 0, 1, 3, 3, 3,
      32'h2, 32'h2, 32'h2, 4));

    // reset with a write pending
    drive(1, 5, 32'hDEADBEEF, 1, 5, 5, 5);
    rst_n = 1'b0;
    #2;
    step();
    step();
    chk("rst_A", A, 0);
    chk("rst_B", B, 0);
    chk("rst_cnt", {16'd0, wr_count}, 0);
    drive(0, 0, 0, 0, 0, 0, 5);
    rst_n = 1'b1;
    #1;
    chk("rst_dbg5", dbg_data, 0);
    step();
    chk("rst_dbg5_edge", dbg_data, 0);
    chk("rst_cnt_edge", {16'd0, wr_count}, 0);

    foreach (vecs[i]) begin
      drive(vecs[i].we, vecs[i].wa, vecs[i].wd,
            vecs[i].abwe, vecs[i].rs, vecs[i].rt,
            vecs[i].dbg);
      step();
      chk($sformatf("v%0d_A", i), A, vecs[i].ea);
      chk($sformatf("v%0d_B", i), B, vecs[i].eb);
      chk($sformatf("v%0d_dbg", i), dbg_data, vecs[i].ed);
      chk($sformatf("v%0d_cnt", i),
          {16'd0, wr_count}, {16'd0, vecs[i].ec});
    end

    // asynchronous reset pulse between edges
    drive(0, 0, 0, 0, 3, 3, 3);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    chk("async_A", A, 0);
    chk("async_B", B, 0);
    chk("async_cnt", {16'd0, wr_count}, 0);
    chk("async_dbg3", dbg_data, 0);
    #1;
    rst_n = 1'b1;
    step();
    chk("async_A_hold", A, 0);

    // random traffic against the model
    m_clear();
    for (int n = 0; n < 400; n++) begin
      logic        we, ab, wr;
      logic [4:0]  wa, r_s, r_t, dbg;
      logic [31:0] wd, na, nb;
      we  = 1'($urandom_range(0, 1));
      ab  = 1'($urandom_range(0, 1));
      wa  = 5'($urandom_range(0, 7));
      r_s = 5'($urandom_range(0, 7));
      r_t = 5'($urandom_range(0, 7));
      dbg = 5'($urandom_range(0, 7));
      if (n % 50 == 7) wa = 5'($urandom_range(8, 31));
      wd  = $urandom;
      drive(we, wa, wd, ab, r_s, r_t, dbg);
      wr = we && (wa != 0);
      na = m_a;
      nb = m_b;
      if (ab) begin
        na = (byp && wr && wa == r_s) ? wd : m_rd(r_s);
        nb = (byp && wr && wa == r_t) ? wd : m_rd(r_t);
      end
      m_a = na;
      m_b = nb;
      if (wr) begin
        m_mem[wa] = wd;
        if (m_cnt < 65535) m_cnt++;
      end
      step();
      chk($sformatf("r%0d_A", n), A, m_a);
      chk($sformatf("r%0d_B", n), B, m_b);
      chk($sformatf("r%0d_dbg", n), dbg_data, m_rd(dbg));
      chk($sformatf("r%0d_cnt", n),
          {16'd0, wr_count}, 32'(m_cnt));
    end

    // counter saturation
    do_reset();
    drive(1, 1, 32'hA5A5A5A5, 0, 0, 0, 1);
    repeat (65534) @(posedge clk);
    #1;
    chk("sat_fffe", {16'd0, wr_count}, 32'hFFFE);
    step();
    chk("sat_ffff", {16'd0, wr_count}, 32'hFFFF);
    step();
    step();
    chk("sat_hold", {16'd0, wr_count}, 32'hFFFF);
    chk("sat_dbg", dbg_data, 32'hA5A5A5A5);
    drive(1, 0, 32'h1, 0, 0, 0, 0);
    step();
    chk("sat_zero_wr", {16'd0, wr_count}, 32'hFFFF);
    drive(0, 0, 0, 0, 0, 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
